// File: rtl/adc_capture_ctrl.sv
// Burst capture sequencer for the on-chip ADC: waits for PLL lock, starts the
// sequencer over CSR, stores one channel's samples into sample RAM, then stops it.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; busy low
// WAIT_LOCK | start seen without ADC PLL lock; bounded wait for lock
// CFG       | CSR write 32'h1 (sequencer run continuous)
// RUN       | accepting CHANNEL responses into RAM
// STOP      | CSR write 32'h0 (sequencer stop)
// DONE      | one-cycle done pulse after a complete burst
module adc_capture_ctrl #(
  parameter int         ADDR_W       = 4,
  parameter int         NUM_SAMPLES  = 16,
  parameter logic [4:0] CHANNEL      = 5'd1,
  parameter int         LOCK_TIMEOUT = 1000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              adc_locked,
  input  logic              response_valid,
  input  logic [4:0]        response_channel,
  input  logic [11:0]       response_data,
  output logic              csr_address,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [11:0]       ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic [11:0]       last_sample,
  output logic              lock_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_SAMPLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_TIMEOUT - 1);

  if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > (1 << ADDR_W))) begin : g_bad_num_samples
    $error("adc_capture_ctrl: NUM_SAMPLES must be in 1..2**ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    CFG       = 3'd2,
    RUN       = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [TMR_W-1:0]  lock_tmr;
  logic              normal_end;
  logic              accept;
  logic [CNT_W-1:0]  count_inc;

  assign csr_address = 1'b0;
  assign accept      = response_valid && (response_channel == CHANNEL);
  assign count_inc   = sample_count + 1'b1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      lock_tmr      <= '0;
      normal_end    <= 1'b0;
      csr_write     <= 1'b0;
      csr_writedata <= '0;
      ram_address   <= '0;
      ram_data      <= '0;
      ram_wren      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sample_count  <= '0;
      last_sample   <= '0;
      lock_err      <= 1'b0;
    end else begin
      ram_wren      <= 1'b0;
      done          <= 1'b0;
      csr_write     <= 1'b0;
      csr_writedata <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            sample_count <= '0;
            wr_ptr       <= '0;
            lock_err     <= 1'b0;
            normal_end   <= 1'b0;
            busy         <= 1'b1;
            if (adc_locked) begin
              state         <= CFG;
              csr_write     <= 1'b1;
              csr_writedata <= 32'h1;
            end else begin
              state    <= WAIT_LOCK;
              lock_tmr <= TMR_LOAD;
            end
          end
        end

        WAIT_LOCK: begin
          if (adc_locked) begin
            state         <= CFG;
            csr_write     <= 1'b1;
            csr_writedata <= 32'h1;
          end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (lock_tmr == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            lock_err <= 1'b1;
          end else begin
            lock_tmr <= lock_tmr - 1'b1;
          end
        end

        CFG: state <= RUN;

        RUN: begin
          // Abort and lock loss win over a response arriving in the same cycle.
          if (abort || !adc_locked) begin
            state     <= STOP;
            csr_write <= 1'b1;
            if (!adc_locked) lock_err <= 1'b1;
          end else if (accept) begin
            ram_wren     <= 1'b1;
            ram_address  <= wr_ptr;
            ram_data     <= response_data;
            wr_ptr       <= wr_ptr + 1'b1;
            sample_count <= count_inc;
            last_sample  <= response_data;
            if (count_inc == NUM_LAST) begin
              state      <= STOP;
              csr_write  <= 1'b1;
              normal_end <= 1'b1;
            end
          end
        end

        STOP: begin
          if (normal_end) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
